min_pooling_mul_pipe: RTL and testbench
=======================================

Name: min_pooling_mul_pipe

Overview:
Parametrised pipelined multiplier with valid/ready flow control, the successor to the fixed-latency ce-only multiplier used by the min-pooling datapath.
- Operand widths, per-operand signedness, pipeline depth and output width are generic.
- A sideband tag travels with each product.
- Pipeline bubbles are collapsed, so partial backpressure does not stall accepted data.
- Sits between the pooling address/scale logic and the output-index stage.

Parameters:
ID, 1, instance identifier; no functional effect
NUM_STAGE, 4, cycles from input accept to out_valid with no stall; legal range 2..8
din0_WIDTH, 62, width of operand 0
din1_WIDTH, 32, width of operand 1
dout_WIDTH, 64, result width; may be narrower or wider than din0_WIDTH+din1_WIDTH
DIN0_SIGNED, 0, 1 = din0 is two's complement; 0 = zero-extended
DIN1_SIGNED, 1, 1 = din1 is two's complement; 0 = zero-extended
TAG_WIDTH, 8, width of sideband tag

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
ce  in  1  global clock enable; 0 freezes all state
in_valid  in  1  operand pair valid
in_ready  out  1  stage 0 can accept
din0  in  din0_WIDTH  operand 0
din1  in  din1_WIDTH  operand 1
in_tag  in  TAG_WIDTH  sideband tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
dout  out  dout_WIDTH  product
out_tag  out  TAG_WIDTH  tag of the product
out_sat  out  1  product was clamped (only with MUL_SAT_EN; else constant 0)

Behaviour:
- Reset: clk edge with reset=0 clears all stage valid bits and all data/tag registers to 0. During reset, out_valid=0, dout=0, out_tag=0, out_sat=0, in_ready=0. Reset mid-flight discards all in-flight products, with no output.
- Stage structure:
  - Stage 0 registers the operands and tag.
  - Stage 1 registers the full product, of width P = din0_WIDTH+din1_WIDTH+1, with each operand extended per its *_SIGNED setting.
  - Stages 2..NUM_STAGE-1 are delay registers.
  - dout comes from the last stage register. There is no combinational path from din to dout.
- Advance rule: stage k loads when ce=1 and (!v[k] or stage k advances onward). The last stage advances when out_ready=1.
- in_ready = reset & ce & (!v[0] | adv[0]). It is combinational from out_ready through the advance chain.
- Accept: in_valid & in_ready. Output transfer: out_valid & out_ready & ce.
- ce=0: nothing moves and out_valid/dout hold. A consumer must not count a transfer while ce=0.
- Latency: exactly NUM_STAGE cycles with out_ready held 1. Throughput is 1 per cycle.
- Bubbles: an empty stage is filled even while later stages are stalled. With N stages stalled, exactly N results are held and none are lost or duplicated.
- Ordering: results leave in strict input order, and each tag stays aligned with its product.
- Width rule:
  - dout_WIDTH >= P: dout is the product sign-extended if either operand is signed, zero-extended otherwise.
  - dout_WIDTH < P: dout is the low dout_WIDTH bits (truncation).
- in_valid=1 with in_ready=0: the input is not consumed, and the source must hold its values.

Optional Feature:
MIN_POOLING_MUL_SAT_EN
- Defined, dout_WIDTH < P: the product is clamped to the signed dout range if either operand is signed, else to the unsigned range. out_sat=1 on the clamped result, computed in the stage-1 to stage-2 path. Latency is unchanged.
- Not defined: truncation only, and out_sat is tied 0.

Decomposition:
- Package min_pooling_mul_pkg:
  - function prod_width(w0, w1), returning P
  - functions sat_max and sat_min(width, signed)
  - constants NUM_STAGE_MIN=2 and NUM_STAGE_MAX=8
- Sub-module min_pooling_mul_stage, parametrised by payload width: one valid+payload register with the load/advance logic and synchronous active-low clear. It is instantiated NUM_STAGE times via generate; the multiply sits between instance 0 and instance 1.

Test Plan:
- Signed multiply, defaults: din0=5, din1=-3 (0xFFFFFFFD), tag 0x11, out_ready=1 -> dout=0xFFFF_FFFF_FFFF_FFF1 and out_tag=0x11 exactly 4 cycles after accept.
- Streaming: 16 back-to-back pairs (i, i+1) with out_ready=1 -> 16 consecutive out_valid cycles, dout=i*(i+1) in order, and in_ready never drops.
- Backpressure: hold out_ready=0 for 6 cycles while streaming -> in_ready drops after 4 accepts, nothing is lost or duplicated, and order and tags are preserved. Release out_ready -> one result per cycle.
- Bubble collapse: accept one item, wait 2 cycles, hold out_ready=0, send 3 more -> all 4 end up resident, and in_ready=0 only once every stage is full.
- ce=0 for 3 cycles mid-stream -> all outputs hold, with no accept and no transfer. Resuming adds exactly 3 cycles of latency.
- Reset mid-flight with 3 items in the pipe -> next cycle out_valid=0 and dout=0, and no stale result appears afterwards.
- Saturation, with dout_WIDTH=16, both operands signed, din0=300, din1=200: macro defined -> dout=32767, out_sat=1. Macro undefined -> dout=0xEA60, out_sat=0.

Source files
------------

// File: rtl/min_pooling_mul_pkg.sv
// ---------------------------------------------------------------------------
// min_pooling_mul_pkg : shared sizing and saturation helpers for the multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package min_pooling_mul_pkg;

  localparam int NUM_STAGE_MIN = 2;
  localparam int NUM_STAGE_MAX = 8;
  // Working width for clamp comparisons; products must stay narrower.
  localparam int SAT_W = 256;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_max(input int width, input bit is_signed);
    logic signed [SAT_W-1:0] one;
    one = 1;
    if (is_signed) return (one <<< (width - 1)) - one;
    return (one <<< width) - one;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_min(input int width, input bit is_signed);
    logic signed [SAT_W-1:0] one;
    one = 1;
    if (is_signed) return -(one <<< (width - 1));
    return '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/min_pooling_mul_stage.sv
// ---------------------------------------------------------------------------
// min_pooling_mul_stage : one valid+payload pipeline register with elastic load
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module min_pooling_mul_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         down_ready,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Loads into an empty slot even when downstream is stalled.
  assign ready = ce & (~r_valid | down_ready);
  assign valid = r_valid;
  assign data  = r_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (ready) begin
      r_valid <= up_valid;
      if (up_valid) r_data <= up_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/min_pooling_mul_pipe.sv
// ---------------------------------------------------------------------------
// min_pooling_mul_pipe : elastic pipelined multiplier with tag sideband.
// Optional clamp on narrow outputs: MIN_POOLING_MUL_SAT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module min_pooling_mul_pipe
  import min_pooling_mul_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 4,
  parameter int din0_WIDTH  = 62,
  parameter int din1_WIDTH  = 32,
  parameter int dout_WIDTH  = 64,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_sat
);

  localparam int P          = prod_width(din0_WIDTH, din1_WIDTH);
  localparam bit ANY_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
  localparam int W0         = TAG_WIDTH + din0_WIDTH + din1_WIDTH;
  localparam int W1         = TAG_WIDTH + P;
  localparam int WD         = TAG_WIDTH + 1 + dout_WIDTH;

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_depth
    $error("min_pooling_mul_pipe: NUM_STAGE out of range");
  end

  logic [31:0]           unused_id;
  logic [NUM_STAGE-1:0]  v, rdy, down_rdy;
  logic [W0-1:0]         w_s0;
  logic [W1-1:0]         w_s1;
  logic [P-1:0]          w_a_ext, w_b_ext, w_prod, w_p1;
  logic [TAG_WIDTH-1:0]  w_tag1;
  logic [dout_WIDTH-1:0] w_res;
  logic                  w_sat;

  assign unused_id = ID;
  assign down_rdy  = {out_ready, rdy[NUM_STAGE-1:1]};
  assign in_ready  = reset & rdy[0];

  min_pooling_mul_stage #(.W(W0)) u_s0 (
    .clk(clk), .reset(reset), .ce(ce),
    .up_valid(in_valid), .up_data({in_tag, din0, din1}),
    .down_ready(down_rdy[0]), .ready(rdy[0]), .valid(v[0]), .data(w_s0)
  );

  assign w_a_ext = {{(P-din0_WIDTH){w_s0[din0_WIDTH+din1_WIDTH-1] & (DIN0_SIGNED != 0)}},
                    w_s0[din0_WIDTH+din1_WIDTH-1:din1_WIDTH]};
  assign w_b_ext = {{(P-din1_WIDTH){w_s0[din1_WIDTH-1] & (DIN1_SIGNED != 0)}},
                    w_s0[din1_WIDTH-1:0]};
  // Both operands already extended to P bits, so the P-bit modular product is exact.
  assign w_prod  = w_a_ext * w_b_ext;

  min_pooling_mul_stage #(.W(W1)) u_s1 (
    .clk(clk), .reset(reset), .ce(ce),
    .up_valid(v[0]), .up_data({w_s0[W0-1 -: TAG_WIDTH], w_prod}),
    .down_ready(down_rdy[1]), .ready(rdy[1]), .valid(v[1]), .data(w_s1)
  );

  assign w_p1   = w_s1[P-1:0];
  assign w_tag1 = w_s1[W1-1 -: TAG_WIDTH];

  if (dout_WIDTH > P) begin : g_extend
    assign w_res = {{(dout_WIDTH-P){w_p1[P-1] & ANY_SIGNED}}, w_p1};
    assign w_sat = 1'b0;
  end else if (dout_WIDTH == P) begin : g_exact
    assign w_res = w_p1;
    assign w_sat = 1'b0;
  end else begin : g_narrow
`ifdef MIN_POOLING_MUL_SAT_EN
    localparam logic signed [SAT_W-1:0] HI = sat_max(dout_WIDTH, ANY_SIGNED);
    localparam logic signed [SAT_W-1:0] LO = sat_min(dout_WIDTH, ANY_SIGNED);
    logic signed [SAT_W-1:0] w_p_wide;
    assign w_p_wide = {{(SAT_W-P){w_p1[P-1] & ANY_SIGNED}}, w_p1};
    always_comb begin
      w_res = w_p_wide[dout_WIDTH-1:0];
      w_sat = 1'b0;
      if (w_p_wide > HI) begin
        w_res = HI[dout_WIDTH-1:0];
        w_sat = 1'b1;
      end else if (w_p_wide < LO) begin
        w_res = LO[dout_WIDTH-1:0];
        w_sat = 1'b1;
      end
    end
`else
    logic w_unused_high;
    assign w_unused_high = ^w_p1[P-1:dout_WIDTH];
    assign w_res = w_p1[dout_WIDTH-1:0];
    assign w_sat = 1'b0;
`endif
  end

  if (NUM_STAGE == 2) begin : g_short
    assign out_valid = v[1];
    assign dout      = w_res;
    assign out_tag   = w_tag1;
    assign out_sat   = w_sat;
  end else begin : g_delay
    logic [WD-1:0] w_d [NUM_STAGE-1:1];
    assign w_d[1] = {w_tag1, w_sat, w_res};
    for (genvar k = 2; k < NUM_STAGE; k++) begin : g_stage
      min_pooling_mul_stage #(.W(WD)) u_sk (
        .clk(clk), .reset(reset), .ce(ce),
        .up_valid(v[k-1]), .up_data(w_d[k-1]),
        .down_ready(down_rdy[k]), .ready(rdy[k]), .valid(v[k]), .data(w_d[k])
      );
    end
    assign out_valid                = v[NUM_STAGE-1];
    assign {out_tag, out_sat, dout} = w_d[NUM_STAGE-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_min_pooling_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_min_pooling_mul_pipe : directed scoreboard bench for min_pooling_mul_pipe
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_min_pooling_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ce, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [61:0] din0;
  logic [31:0] din1;
  logic [7:0]  in_tag, out_tag;
  logic [63:0] dout;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat;
  logic [15:0] s_din0, s_din1, s_dout;
  logic [7:0]  s_in_tag, s_out_tag;

  int          n_vec = 0;
  int          n_err = 0;
  logic [71:0] sb [$];
  logic [71:0] mon_e;
  int          cnt, first, last, j, n;

`ifdef MIN_POOLING_MUL_SAT_EN
  localparam logic [15:0] SAT_EXP_DOUT = 16'h7FFF;
  localparam logic        SAT_EXP_FLAG = 1'b1;
`else
  localparam logic [15:0] SAT_EXP_DOUT = 16'hEA60;
  localparam logic        SAT_EXP_FLAG = 1'b0;
`endif

  min_pooling_mul_pipe u_dut (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_tag(out_tag), .out_sat(out_sat)
  );

  min_pooling_mul_pipe #(
    .ID(2), .NUM_STAGE(4), .din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(16),
    .DIN0_SIGNED(1), .DIN1_SIGNED(1), .TAG_WIDTH(8)
  ) u_dut_sat (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .din0(s_din0), .din1(s_din1), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .dout(s_dout), .out_tag(s_out_tag), .out_sat(s_out_sat)
  );

  // Default instance: din0 unsigned 62 bit, din1 signed 32 bit, low 64 bits kept.
  function automatic logic [63:0] model(input logic [61:0] a, input logic [31:0] b);
    logic [63:0] ax, bx;
    ax = {2'b00, a};
    bx = {{32{b[31]}}, b};
    return ax * bx;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [61:0] a, input logic [31:0] b, input logic [7:0] t);
    in_valid = v;
    din0     = a;
    din1     = b;
    in_tag   = t;
  endtask

  // Scoreboard: retire on transfer, then record any accept in the same cycle.
  always @(negedge clk) begin
    if (reset && ce && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("stray_output", 128'(out_valid), 128'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_dout", 128'(dout), 128'(mon_e[63:0]));
        chk("sb_tag", 128'(out_tag), 128'(mon_e[71:64]));
        chk("sb_sat", 128'(out_sat), 128'd0);
      end
    end
    if (reset && in_valid && in_ready) sb.push_back({in_tag, model(din0, din1)});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; ce = 1'b1; out_ready = 1'b1;
    drive(1'b0, 62'd0, 32'd0, 8'd0);
    s_in_valid = 1'b0; s_din0 = 16'd0; s_din1 = 16'd0; s_in_tag = 8'h5A; s_out_ready = 1'b1;
    cyc(); cyc(); smp();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_dout", 128'(dout), 128'd0);
    chk("rst_out_tag", 128'(out_tag), 128'd0);
    chk("rst_out_sat", 128'(out_sat), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    cyc();
    reset = 1'b1;

    // Single signed product and its latency
    drive(1'b1, 62'd5, 32'hFFFF_FFFD, 8'h11);
    smp(); chk("t1_in_ready", 128'(in_ready), 128'd1);
    cyc(); drive(1'b0, 62'd0, 32'd0, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      smp();
      chk("t1_latency", 128'(out_valid), 128'(k == 4));
      if (out_valid) begin
        chk("t1_dout", 128'(dout), 128'hFFFF_FFFF_FFFF_FFF1);
        chk("t1_tag", 128'(out_tag), 128'h11);
      end
      cyc();
    end

    // Narrow signed instance: clamp or truncate depending on build
    s_in_valid = 1'b1; s_din0 = 16'd300; s_din1 = 16'd200;
    smp(); chk("sat_in_ready", 128'(s_in_ready), 128'd1);
    cyc(); s_in_valid = 1'b0;
    n = 0;
    smp();
    while (!s_out_valid && n < 10) begin cyc(); smp(); n++; end
    chk("sat_latency", 128'(n), 128'd3);
    chk("sat_dout", 128'(s_dout), 128'(SAT_EXP_DOUT));
    chk("sat_flag", 128'(s_out_sat), 128'(SAT_EXP_FLAG));
    chk("sat_tag", 128'(s_out_tag), 128'h5A);
    cyc(); cyc();

    // Streaming 16 back-to-back pairs
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 22; c++) begin
      if (c < 16) drive(1'b1, 62'(c), 32'(c + 1), 8'(c + 32));
      else        drive(1'b0, 62'd0, 32'd0, 8'd0);
      smp();
      if (c < 16) chk("t2_in_ready", 128'(in_ready), 128'd1);
      if (out_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
      cyc();
    end
    chk("t2_count", 128'(cnt), 128'd16);
    chk("t2_first", 128'(first), 128'd4);
    chk("t2_contig", 128'(last - first), 128'd15);

    // Backpressure: 6 stalled cycles, then release
    out_ready = 1'b0; j = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 62'(100 + j), 32'hFFFF_FF00 + 32'(j), 8'(j + 8'h80));
      smp();
      if (in_valid && in_ready) j++;
      cyc();
    end
    chk("t3_accepts", 128'(j), 128'd4);
    smp();
    chk("t3_full_ready", 128'(in_ready), 128'd0);
    chk("t3_full_valid", 128'(out_valid), 128'd1);
    cyc();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (j < 8) drive(1'b1, 62'(100 + j), 32'hFFFF_FF00 + 32'(j), 8'(j + 8'h80));
      else       drive(1'b0, 62'd0, 32'd0, 8'd0);
      smp();
      if (c < 4) chk("t3_release", 128'(out_valid), 128'd1);
      if (in_valid && in_ready) j++;
      cyc();
    end
    chk("t3_drained", 128'(sb.size()), 128'd0);

    // Bubble collapse
    drive(1'b1, 62'hFFFF_FFFF, 32'h8000_0000, 8'h40);
    smp(); chk("t4_first_ready", 128'(in_ready), 128'd1);
    cyc(); drive(1'b0, 62'd0, 32'd0, 8'd0);
    smp(); cyc(); smp(); cyc();
    out_ready = 1'b0;
    for (int q = 0; q < 3; q++) begin
      drive(1'b1, 62'(7 + q), 32'(q + 2), 8'(8'h41 + q));
      smp(); chk("t4_ready_bubble", 128'(in_ready), 128'd1);
      cyc();
    end
    drive(1'b1, 62'd99, 32'd9, 8'h50);
    smp();
    chk("t4_full_ready", 128'(in_ready), 128'd0);
    chk("t4_head_valid", 128'(out_valid), 128'd1);
    chk("t4_head_tag", 128'(out_tag), 128'h40);
    cyc();
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      smp();
      if (in_valid && in_ready) begin cyc(); drive(1'b0, 62'd0, 32'd0, 8'd0); end
      else cyc();
    end
    chk("t4_drained", 128'(sb.size()), 128'd0);

    // ce freeze with a result at the output
    drive(1'b1, 62'd11, 32'd13, 8'h60); smp(); cyc();
    drive(1'b1, 62'd17, 32'hFFFF_FFED, 8'h61); smp(); cyc();
    drive(1'b1, 62'd23, 32'd29, 8'h62); smp(); cyc();
    drive(1'b0, 62'd0, 32'd0, 8'd0);
    smp(); chk("t5_pre", 128'(out_valid), 128'd0); cyc();
    ce = 1'b0;
    drive(1'b1, 62'd5, 32'd5, 8'h6F);
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("t5_hold_valid", 128'(out_valid), 128'd1);
      chk("t5_hold_dout", 128'(dout), 128'(model(62'd11, 32'd13)));
      chk("t5_hold_tag", 128'(out_tag), 128'h60);
      chk("t5_no_accept", 128'(in_ready), 128'd0);
      cyc();
    end
    ce = 1'b1;
    drive(1'b0, 62'd0, 32'd0, 8'd0);
    smp(); chk("t5_resume_x", 128'(out_tag), 128'h60); cyc();
    smp(); chk("t5_y_valid", 128'(out_valid), 128'd1); chk("t5_y_tag", 128'(out_tag), 128'h61); cyc();
    smp(); chk("t5_z_tag", 128'(out_tag), 128'h62); cyc();
    smp(); chk("t5_empty", 128'(out_valid), 128'd0); cyc();

    // Reset with three items in flight
    drive(1'b1, 62'd3, 32'd4, 8'h70); smp(); cyc();
    drive(1'b1, 62'd5, 32'd6, 8'h71); smp(); cyc();
    drive(1'b1, 62'd7, 32'd8, 8'h72); smp(); cyc();
    reset = 1'b0; out_ready = 1'b0;
    drive(1'b0, 62'd0, 32'd0, 8'd0);
    smp(); chk("t6_rst_in_ready", 128'(in_ready), 128'd0);
    cyc();
    sb.delete();
    reset = 1'b1; out_ready = 1'b1;
    smp();
    chk("t6_out_valid", 128'(out_valid), 128'd0);
    chk("t6_dout", 128'(dout), 128'd0);
    chk("t6_out_tag", 128'(out_tag), 128'd0);
    chk("t6_in_ready", 128'(in_ready), 128'd1);
    cyc();
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      smp();
      if (out_valid) cnt++;
      cyc();
    end
    chk("t6_no_stale", 128'(cnt), 128'd0);
    chk("final_sb_empty", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
